// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) with a start/busy/done handshake.
// Optional signed-overflow flag port enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             busy_r;
  logic             done_r;
  logic             borrow_r;
  logic             d_bit_s;
  logic             br_next_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // One-bit full-subtractor cell on the current LSBs
  always_comb begin
    d_bit_s   = 1'b0;
    br_next_s = 1'b0;
    d_bit_s   = fs_diff(sa_r[0], sb_r[0], br_r);
    br_next_s = fs_borrow(sa_r[0], sb_r[0], br_r);
  end

  // Control FSM and serial datapath; result registers only move during RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sa_r     <= '0;
      sb_r     <= '0;
      diff_r   <= '0;
      cnt_r    <= '0;
      br_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      borrow_r <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          sa_r   <= sa_r >> 1;
          sb_r   <= sb_r >> 1;
          br_r   <= br_next_s;
          diff_r <= {d_bit_s, diff_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == LAST_BIT) begin
            // d_bit_s here is the result MSB
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            borrow_r <= br_next_s;
            state_r  <= DONE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_r    <= (a_msb_r != b_msb_r) && (d_bit_s != a_msb_r);
`endif
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf        = ovf_r;
`endif

endmodule
